conv_window_fetch: RTL

- Downstream consumer of the dual-read-port 28x28 8-bit image RAM.
- Scans the stored image and emits every 3x3 window for the convolution engine. Stride is 1 and there is no padding, so the block produces (ROWS-2)*(COLS-2) windows.
- Uses both RAM read ports: one image column (3 pixels) takes 2 cycles. Window output uses a valid/ready handshake.

---
 rtl/npu_pkg.sv | 16 +
 rtl/conv_window_fetch_if.sv | 28 ++
 rtl/conv_window_reg.sv | 33 +++
 rtl/conv_window_fetch.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types and constants: pixel/address widths, fetch FSM states and
// the 3x3 window pixel indexing rule used by all window-producing stages.
package npu_pkg;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 10;
  localparam int WIN_K   = 3;
  localparam int COORD_W = 5;
  localparam int WIN_W   = WIN_K * WIN_K * PIX_W;

  typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B, DRAIN} state_e;

  // Pixel (i,j) of a window lives at byte lane k = 3i + j.
  function automatic int win_idx(input int i, input int j);
    return WIN_K * i + j;
  endfunction
endpackage

// File: rtl/conv_window_fetch_if.sv
// Bundle of the window fetcher's control, RAM read port and window stream.
// Window stream: a transfer happens on every clk edge where win_valid and win_ready are both 1;
// while win_valid=1 and win_ready=0 the window, win_row and win_col hold steady.
interface conv_window_fetch_if;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic [npu_pkg::ADDR_W-1:0]   rd_addr1;
  logic [npu_pkg::ADDR_W-1:0]   rd_addr2;
  logic [npu_pkg::PIX_W-1:0]    rd_data1;
  logic [npu_pkg::PIX_W-1:0]    rd_data2;
  logic [npu_pkg::WIN_W-1:0]    win_data;
  logic [npu_pkg::COORD_W-1:0]  win_row;
  logic [npu_pkg::COORD_W-1:0]  win_col;
  logic                         win_valid;
  logic                         win_ready;
  npu_pkg::state_e              dbg_state;

  modport master (
    input  start, rd_data1, rd_data2, win_ready,
    output busy, done, rd_addr1, rd_addr2, win_data, win_row, win_col, win_valid, dbg_state
  );

  modport slave (
    output start, rd_data1, rd_data2, win_ready,
    input  busy, done, rd_addr1, rd_addr2, win_data, win_row, win_col, win_valid, dbg_state
  );
endinterface

// File: rtl/conv_window_reg.sv
// KxK shifting column register: on shift, columns move left by one and the new
// column enters on the right. Row i of col_i is the top-to-bottom pixel order.
module conv_window_reg
  import npu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        shift_en_i,
  input  logic [WIN_K-1:0][PIX_W-1:0] col_i,
  output logic [WIN_W-1:0]            win_o
);
  // [i][j] packing places pixel (i,j) at lane 3i+j of the flat output.
  logic [WIN_K-1:0][WIN_K-1:0][PIX_W-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (shift_en_i) begin
      for (int i = 0; i < WIN_K; i++) begin
        for (int j = 0; j < WIN_K - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][WIN_K-1] = col_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  assign win_o = win_q;
endmodule

// File: rtl/conv_window_fetch.sv
// Scans a ROWSxCOLS image RAM through two read ports and streams every 3x3
// window (stride 1, no padding) in raster order over a valid/ready handshake.
module conv_window_fetch
  import npu_pkg::*;
#(
  parameter int ROWS = 28,
  parameter int COLS = 28
) (
  input logic                  clk,
  input logic                  rst,
  conv_window_fetch_if.master  bus
);
  localparam logic [ADDR_W-1:0]  COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0]  COLS2_A = ADDR_W'(2 * COLS);
  localparam logic [COORD_W-1:0] C_LAST  = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] R_LAST  = COORD_W'(ROWS - 3);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [PIX_W-1:0]     t0_q, t0_d, t1_q, t1_d;
  logic                 win_valid_q, win_valid_d;
  logic [COORD_W-1:0]   win_row_q, win_row_d, win_col_q, win_col_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 shift_en;
  logic [ADDR_W-1:0]    addr1, addr2, c_ext;
  logic [WIN_K-1:0][PIX_W-1:0] new_col;

  assign c_ext   = {{(ADDR_W-COORD_W){1'b0}}, c_q};
  assign new_col = {bus.rd_data1, t1_q, t0_q};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    base_d      = base_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shift_en    = 1'b0;
    addr1       = '0;
    addr2       = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH_A;
          busy_d  = 1'b1;
          r_d     = '0;
          c_d     = '0;
          base_d  = '0;
        end
      end
      FETCH_A: begin
        addr1 = base_q + c_ext;
        addr2 = base_q + COLS_A + c_ext;
        t0_d  = bus.rd_data1;
        t1_d  = bus.rd_data2;
        if (win_valid_q && bus.win_ready) win_valid_d = 1'b0;
        state_d = FETCH_B;
      end
      FETCH_B: begin
        addr1 = base_q + COLS2_A + c_ext;
        addr2 = base_q + COLS_A + c_ext;
        // A pending window blocks the shift; the next column waits on the bus.
        if (!(win_valid_q && !bus.win_ready)) begin
          shift_en = 1'b1;
          if (c_q >= COORD_W'(2)) begin
            win_valid_d = 1'b1;
            win_row_d   = r_q;
            win_col_d   = c_q - COORD_W'(2);
          end else begin
            win_valid_d = 1'b0;
          end
          if (c_q < C_LAST) begin
            c_d     = c_q + COORD_W'(1);
            state_d = FETCH_A;
          end else if (r_q < R_LAST) begin
            c_d     = '0;
            r_d     = r_q + COORD_W'(1);
            base_d  = base_q + COLS_A;
            state_d = FETCH_A;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.win_ready) begin
          win_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      base_q      <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      base_q      <= base_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  conv_window_reg u_win (
    .clk        (clk),
    .rst_n      (rst),
    .shift_en_i (shift_en),
    .col_i      (new_col),
    .win_o      (bus.win_data)
  );

  assign bus.rd_addr1  = addr1;
  assign bus.rd_addr2  = addr2;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_valid = win_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
endmodule
